icache_fetch: RTL

- Direct-mapped instruction cache and fetch controller, directly downstream of the PC register.
- Takes the current fetch address (PCnext), returns the instruction word to the IF/ID stage, and refills lines from instruction memory over a word-wise req/ready handshake.
- Drives fetch_stall, which the hazard unit uses to deassert PCWrite and freeze IF/ID while a miss is serviced.

---
 rtl/icache_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with miss refill over a word-wise req/ready memory port.
// Hits return in the lookup cycle; a miss stalls fetch for WORDS_PER_LINE*(wait+1)+2 cycles.
module icache_fetch #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;
  state_t state, state_nxt;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [31:0]          data_arr [NUM_LINES][WORDS_PER_LINE];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_pc_bits;

  assign off            = pc[OFF_W+1:2];
  assign idx            = pc[OFF_W+IDX_W+1:OFF_W+2];
  assign tag            = pc[31:OFF_W+IDX_W+2];
  assign unused_pc_bits = ^pc[1:0];

  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [OFF_W-1:0] cnt;
  logic             fill_kill;
  logic             hit, miss, word_done, line_done;

  assign word_done = (state == REFILL) && mem_ready;
  assign line_done = word_done && (cnt == LAST_WORD);

  // Lookup outputs are gated by rst so nothing asserts while reset is held.
  always_comb begin
    state_nxt   = state;
    hit         = 1'b0;
    miss        = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    fetch_stall = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    case (state)
      IDLE: begin
        if (fetch_en && rst) begin
          if (valid[idx] && (tag_arr[idx] == tag)) begin
            hit         = 1'b1;
            instr_valid = 1'b1;
            instr       = data_arr[idx][off];
          end else begin
            miss        = 1'b1;
            fetch_stall = 1'b1;
            state_nxt   = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req     = 1'b1;
        mem_addr    = {fill_tag, fill_idx, cnt, 2'b00};
        fetch_stall = 1'b1;
        if (line_done) state_nxt = FILL_DONE;
      end
      FILL_DONE: begin
        fetch_stall = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid      <= '0;
      cnt        <= '0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      fill_kill  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nxt;
      if (hit && (hit_count != '1)) hit_count <= hit_count + 32'd1;
      if (miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
      if (miss) begin
        fill_tag  <= tag;
        fill_idx  <= idx;
        cnt       <= '0;
        fill_kill <= 1'b0;
      end
      if (word_done) cnt <= cnt + 1'b1;
      // A flush seen at any point of a refill keeps that line from becoming valid.
      if (flush) begin
        valid <= '0;
        if (state == REFILL) fill_kill <= 1'b1;
      end else if (line_done && !fill_kill) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_done) data_arr[fill_idx][cnt] <= mem_rdata;
    if (line_done) tag_arr[fill_idx] <= fill_tag;
  end
endmodule
